wb_scoreboard: RTL and testbench

Write-back stage and register-write scoreboard for the pipelined CPU. It holds the MEM/WB pipeline register and drives the register-file write port (`we`, `wr`, `wD`). It also counts in-flight writes per architectural register and tells ID when a source register still has a pending write, so ID can raise a suspend request. This block is the write end of the register-file interface whose read end lives in the decoder.

---
 rtl/wb_scoreboard.sv | 111 +++++++++++
 tb/tb_wb_scoreboard.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_scoreboard.sv
// Write-back stage: MEM/WB pipeline register driving the register-file write port,
// plus per-register pending-write counters that raise a RAW stall toward ID.
module wb_scoreboard #(
  parameter logic [1:0] RETURN_PC    = 2'b00,
  parameter logic [1:0] ALU_RESULT   = 2'b01,
  parameter logic [1:0] MEM_DATA     = 2'b10,
  parameter int         MAX_INFLIGHT = 3
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        mem_valid_i,
  input  logic        mem_we_i,
  input  logic [4:0]  mem_wr_i,
  input  logic [1:0]  mem_wd_sel_i,
  input  logic [31:0] mem_return_pc_i,
  input  logic [31:0] mem_alu_result_i,
  input  logic [31:0] mem_data_i,
  input  logic        issue_i,
  input  logic        issue_we_i,
  input  logic [4:0]  issue_wr_i,
  input  logic        squash_i,
  input  logic [4:0]  squash_wr_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic        id_rs1_used_i,
  input  logic        id_rs2_used_i,
  output logic        we_o,
  output logic [4:0]  wr_o,
  output logic [31:0] wd_o,
  output logic        stall_o,
  output logic        err_o
);
  // Counter values are carried with a +2 offset so the sum never goes negative.
  localparam logic [3:0] LP_OFS = 4'd2;
  localparam logic [3:0] LP_HI  = 4'(MAX_INFLIGHT + 2);

  logic        r_we;
  logic [4:0]  r_wr;
  logic [1:0]  r_sel;
  logic [31:0] r_pc, r_alu, r_mem;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_we  <= 1'b0;
      r_wr  <= 5'd0;
      r_sel <= RETURN_PC;
      r_pc  <= 32'd0;
      r_alu <= 32'd0;
      r_mem <= 32'd0;
    end else begin
      r_we  <= mem_we_i & mem_valid_i & (mem_wr_i != 5'd0);
      r_wr  <= mem_wr_i;
      r_sel <= mem_wd_sel_i;
      r_pc  <= mem_return_pc_i;
      r_alu <= mem_alu_result_i;
      r_mem <= mem_data_i;
    end
  end

  always_comb begin
    wd_o = 32'd0;
    case (r_sel)
      RETURN_PC:  wd_o = r_pc;
      ALU_RESULT: wd_o = r_alu;
      MEM_DATA:   wd_o = r_mem;
      default:    wd_o = 32'd0;
    endcase
  end

  assign we_o = r_we;
  assign wr_o = r_wr;

  logic [31:1][1:0] r_pend;
  logic [31:1][1:0] w_nxt;
  logic [31:1]      w_ovf, w_unf;
  logic             r_err;

  genvar g;
  generate
    for (g = 1; g < 32; g++) begin : g_reg
      logic       w_inc, w_dc, w_ds;
      logic [3:0] w_sum;
      assign w_inc = issue_i & issue_we_i & (issue_wr_i == 5'(g));
      assign w_dc  = r_we & (r_wr == 5'(g));
      assign w_ds  = squash_i & (squash_wr_i == 5'(g));
      assign w_sum = {2'b00, r_pend[g]} + LP_OFS + 4'(w_inc) - 4'(w_dc) - 4'(w_ds);
      assign w_ovf[g] = (w_sum > LP_HI);
      assign w_unf[g] = (w_sum < LP_OFS);
      assign w_nxt[g] = w_ovf[g] ? 2'(MAX_INFLIGHT) :
                        w_unf[g] ? 2'd0 : (w_sum[1:0] - 2'd2);
    end
  endgenerate

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_pend <= '0;
      r_err  <= 1'b0;
    end else begin
      r_pend <= w_nxt;
      r_err  <= r_err | (|w_ovf) | (|w_unf);
    end
  end

  // x0 slot is hard-wired to zero so it never stalls.
  logic [31:0][1:0] w_pend_all;
  assign w_pend_all = {r_pend, 2'b00};

  assign stall_o = (id_rs1_used_i & (w_pend_all[id_rs1_i] != 2'd0)) |
                   (id_rs2_used_i & (w_pend_all[id_rs2_i] != 2'd0));
  assign err_o   = r_err;
endmodule

// File: tb/tb_wb_scoreboard.sv
// Randomized + directed bench for wb_scoreboard against a per-register count model.
module tb_wb_scoreboard;
  logic        clk = 1'b0, rst = 1'b1;
  logic        mem_valid, mem_we, issue, issue_we, squash, rs1_used, rs2_used;
  logic [4:0]  mem_wr, issue_wr, squash_wr, rs1, rs2;
  logic [1:0]  mem_sel;
  logic [31:0] mem_pc, mem_alu, mem_data;
  logic        we_o, stall_o, err_o;
  logic [4:0]  wr_o;
  logic [31:0] wd_o;

  int n_chk = 0, n_bad = 0;

  // model state
  int          pend [32];
  bit          m_err, m_we;
  int          m_wr;
  logic [31:0] m_wd;

  wb_scoreboard dut (
    .clk_i(clk), .reset_i(rst),
    .mem_valid_i(mem_valid), .mem_we_i(mem_we), .mem_wr_i(mem_wr), .mem_wd_sel_i(mem_sel),
    .mem_return_pc_i(mem_pc), .mem_alu_result_i(mem_alu), .mem_data_i(mem_data),
    .issue_i(issue), .issue_we_i(issue_we), .issue_wr_i(issue_wr),
    .squash_i(squash), .squash_wr_i(squash_wr),
    .id_rs1_i(rs1), .id_rs2_i(rs2), .id_rs1_used_i(rs1_used), .id_rs2_used_i(rs2_used),
    .we_o(we_o), .wr_o(wr_o), .wd_o(wd_o), .stall_o(stall_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    mem_valid = 0; mem_we = 0; mem_wr = 0; mem_sel = 0;
    mem_pc = 0; mem_alu = 0; mem_data = 0;
    issue = 0; issue_we = 0; issue_wr = 0; squash = 0; squash_wr = 0;
    rs1 = 0; rs2 = 0; rs1_used = 0; rs2_used = 0;
  endtask

  task automatic model_clear();
    foreach (pend[i]) pend[i] = 0;
    m_err = 0; m_we = 0; m_wr = 0; m_wd = 0;
  endtask

  function automatic bit model_stall();
    bit s1, s2;
    s1 = rs1_used && rs1 != 0 && pend[rs1] > 0;
    s2 = rs2_used && rs2 != 0 && pend[rs2] > 0;
    return s1 || s2;
  endfunction

  // Applies one clock edge's worth of events to the model.
  task automatic model_step();
    logic [31:0] src [4];
    for (int r = 1; r < 32; r++) begin
      int n;
      n = pend[r];
      if (issue && issue_we && issue_wr == r) n++;
      if (m_we && m_wr == r) n--;
      if (squash && squash_wr == r) n--;
      if (n > 3) begin n = 3; m_err = 1; end
      if (n < 0) begin n = 0; m_err = 1; end
      pend[r] = n;
    end
    src[0] = mem_pc; src[1] = mem_alu; src[2] = mem_data; src[3] = 32'h0;
    m_we = mem_valid && mem_we && mem_wr != 0;
    m_wr = mem_wr;
    m_wd = src[mem_sel];
  endtask

  // Called at a falling edge with inputs already set.
  task automatic cycle();
    #1;
    chk("we", {31'd0, we_o}, {31'd0, m_we});
    chk("wr", {27'd0, wr_o}, 32'(m_wr));
    chk("wd", wd_o, m_wd);
    chk("stall", {31'd0, stall_o}, {31'd0, model_stall()});
    chk("err", {31'd0, err_o}, {31'd0, m_err});
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic async_rst();
    idle();
    #2 rst = 1;
    #1;
    chk("ar_we", {31'd0, we_o}, 0);
    chk("ar_wr", {27'd0, wr_o}, 0);
    chk("ar_wd", wd_o, 0);
    chk("ar_stall", {31'd0, stall_o}, 0);
    chk("ar_err", {31'd0, err_o}, 0);
    model_clear();
    #1 rst = 0;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_issue(input int r);
    issue = 1; issue_we = 1; issue_wr = 5'(r);
  endtask

  task automatic do_mem(input int r, input logic [1:0] sel, input logic [31:0] v);
    mem_valid = 1; mem_we = 1; mem_wr = 5'(r); mem_sel = sel;
    mem_pc = ~v; mem_alu = v; mem_data = v ^ 32'h5555_5555;
  endtask

  initial begin
    idle();
    model_clear();
    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    chk("rst_we", {31'd0, we_o}, 0);
    chk("rst_wd", wd_o, 0);
    chk("rst_err", {31'd0, err_o}, 0);
    @(negedge clk);

    // basic write-back with alu select, then select 11
    do_issue(5); cycle(); idle();
    do_mem(5, 2'b01, 32'hDEADBEEF); cycle(); idle();
    #1;
    chk("d_we", {31'd0, we_o}, 1);
    chk("d_wr", {27'd0, wr_o}, 5);
    chk("d_wd", wd_o, 32'hDEADBEEF);
    mem_valid = 1; mem_sel = 2'b11; mem_alu = 32'h1234; cycle(); idle();
    #1 chk("d_sel3", wd_o, 0);
    cycle();

    // RAW on x7 through commit
    do_issue(7); cycle(); idle();
    rs1 = 7; rs1_used = 1;
    #1 chk("x7_stall", {31'd0, stall_o}, 1);
    do_mem(7, 2'b10, 32'hA5A5_0007); cycle();
    idle(); rs1 = 7; rs1_used = 1;
    #1 chk("x7_commit_stall", {31'd0, stall_o}, 1);
    cycle();
    #1 chk("x7_clear", {31'd0, stall_o}, 0);
    cycle(); idle();

    // issue on x3 coincident with its commit
    do_issue(3); cycle(); idle();
    do_mem(3, 2'b01, 32'h3); cycle(); idle();
    do_issue(3); rs1 = 3; rs1_used = 1; cycle(); idle();
    rs1 = 3; rs1_used = 1;
    #1 chk("x3_hold", {31'd0, stall_o}, 1);
    do_mem(3, 2'b01, 32'h33); cycle();
    idle(); rs1 = 3; rs1_used = 1; cycle();
    #1 chk("x3_clear", {31'd0, stall_o}, 0);
    cycle(); idle();

    // x0 is never written nor tracked
    do_issue(0); do_mem(0, 2'b01, 32'hFFFF); cycle(); idle();
    rs1 = 0; rs2 = 0; rs1_used = 1; rs2_used = 1;
    #1;
    chk("x0_we", {31'd0, we_o}, 0);
    chk("x0_stall", {31'd0, stall_o}, 0);
    cycle(); idle();

    // squash clears; squash of idle register is an error
    do_issue(9); cycle(); idle();
    rs2 = 9; rs2_used = 1;
    #1 chk("x9_stall", {31'd0, stall_o}, 1);
    squash = 1; squash_wr = 9; cycle();
    squash = 0;
    #1;
    chk("x9_clear", {31'd0, stall_o}, 0);
    chk("x9_noerr", {31'd0, err_o}, 0);
    squash = 1; cycle(); idle();
    #1 chk("sq_err", {31'd0, err_o}, 1);
    repeat (3) cycle();
    chk("sq_sticky", {31'd0, err_o}, 1);
    async_rst();

    // overflow on x4
    repeat (4) begin do_issue(4); cycle(); end
    idle(); rs1 = 4; rs1_used = 1;
    #1;
    chk("ovf_err", {31'd0, err_o}, 1);
    chk("ovf_stall", {31'd0, stall_o}, 1);
    do_mem(4, 2'b00, 32'h44); async_rst();
    cycle();

    // randomized traffic, small register range to force collisions
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 149) == 0) async_rst();
      mem_valid = ($urandom_range(0, 9) < 4);
      mem_we    = $urandom_range(0, 1);
      mem_wr    = 5'($urandom_range(0, 7));
      mem_sel   = 2'($urandom_range(0, 3));
      mem_pc    = $urandom; mem_alu = $urandom; mem_data = $urandom;
      issue     = ($urandom_range(0, 9) < 3) && !stall_o;
      issue_we  = ($urandom_range(0, 3) != 0);
      issue_wr  = 5'($urandom_range(0, 7));
      squash    = ($urandom_range(0, 19) == 0);
      squash_wr = 5'($urandom_range(0, 7));
      rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 31));
      rs1_used = $urandom_range(0, 1); rs2_used = $urandom_range(0, 1);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
